// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// Module   : rename_free_list
// Brief    : Circular free list of physical register ids with multi-lane
//            allocate/release and a committed-head checkpoint for flush.
// Revision : 1.0
// ============================================================================
module rename_free_list #(
    parameter int  PRF_NUM       = 64,
    parameter int  ARF_NUM       = 32,
    parameter int  PRF_WIDTH     = 6,
    parameter int  ALLOC_WIDTH   = 2,
    parameter int  RELEASE_WIDTH = 2,
    parameter bit  OVF_ASSERT_EN = 1'b1,
    localparam int FL_DEPTH      = PRF_NUM - ARF_NUM,
    localparam int CNT_W         = $clog2(FL_DEPTH) + 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ALLOC_WIDTH-1:0]             alloc_req,
    output logic [ALLOC_WIDTH*PRF_WIDTH-1:0]   alloc_prf_id,
    output logic                               alloc_ready,
    input  logic [RELEASE_WIDTH-1:0]           retire_valid,
    input  logic [RELEASE_WIDTH-1:0]           retire_wb,
    input  logic [RELEASE_WIDTH*PRF_WIDTH-1:0] retire_T_old,
    input  logic                               flush,
    output logic [CNT_W-1:0]                   free_count,
    output logic                               err_overflow
);

    localparam int PTR_W = CNT_W;
    localparam int IDX_W = CNT_W - 1;
    localparam logic [PTR_W-1:0] c_full_tail = PTR_W'(FL_DEPTH);

    if (PRF_WIDTH != $clog2(PRF_NUM)) begin : g_bad_prf_width
        $error("rename_free_list: PRF_WIDTH must equal clog2(PRF_NUM)");
    end
    if ((FL_DEPTH < 2) || ((FL_DEPTH & (FL_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rename_free_list: PRF_NUM-ARF_NUM must be a power of two >= 2");
    end

    logic [PRF_WIDTH-1:0] r_entry [FL_DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_commit_head;
    logic [PTR_W-1:0]     r_tail;
    logic                 r_err;

    logic [CNT_W-1:0]     w_free_count;
    logic [CNT_W-1:0]     w_alloc_n;
    logic [IDX_W-1:0]     w_rd_idx [ALLOC_WIDTH];
    logic                 w_fire;

    logic [RELEASE_WIDTH-1:0] w_rel_en;
    logic [CNT_W-1:0]         w_rel_n;
    logic [IDX_W-1:0]         w_wr_idx [RELEASE_WIDTH];
    logic                     w_overflow;

    logic [PTR_W-1:0]     w_commit_next;
    logic [PTR_W-1:0]     w_head_next;

    // Occupancy is the pointer distance; the wrap bit makes full != empty.
    assign w_free_count = r_tail - r_head;
    assign free_count   = w_free_count;
    assign err_overflow = r_err;

    // Each requesting lane takes the next id after those of lower lanes.
    always_comb begin
        w_alloc_n = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            w_rd_idx[i] = r_head[IDX_W-1:0] + w_alloc_n[IDX_W-1:0];
            w_alloc_n   = w_alloc_n + CNT_W'(alloc_req[i]);
        end
    end

    always_comb begin
        alloc_prf_id = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_prf_id[i*PRF_WIDTH +: PRF_WIDTH] = r_entry[w_rd_idx[i]];
        end
    end

    assign alloc_ready = (w_free_count >= w_alloc_n);
    assign w_fire      = alloc_ready & (|alloc_req) & ~flush;

    assign w_rel_en = retire_valid & retire_wb;

    // Releasing lanes are packed at the tail in lane order.
    always_comb begin
        w_rel_n = '0;
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            w_wr_idx[j] = r_tail[IDX_W-1:0] + w_rel_n[IDX_W-1:0];
            w_rel_n     = w_rel_n + CNT_W'(w_rel_en[j]);
        end
    end

    assign w_overflow = ({1'b0, w_free_count} + {1'b0, w_rel_n}) > (CNT_W+1)'(FL_DEPTH);

    assign w_commit_next = r_commit_head + w_rel_n;

    // Flush rewinds to the checkpoint including this cycle's retires.
    always_comb begin
        w_head_next = r_head;
        if (flush) begin
            w_head_next = w_commit_next;
        end else if (w_fire) begin
            w_head_next = r_head + w_alloc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_entry[i] <= PRF_WIDTH'(ARF_NUM + i);
            end
            r_head        <= '0;
            r_commit_head <= '0;
            r_tail        <= c_full_tail;
            r_err         <= 1'b0;
        end else begin
            for (int j = 0; j < RELEASE_WIDTH; j++) begin
                if (w_rel_en[j]) begin
                    r_entry[w_wr_idx[j]] <= retire_T_old[j*PRF_WIDTH +: PRF_WIDTH];
                end
            end
            r_tail        <= r_tail + w_rel_n;
            r_commit_head <= w_commit_next;
            r_head        <= w_head_next;
            r_err         <= r_err | w_overflow;
        end
    end

    if (OVF_ASSERT_EN) begin : g_ovf_assert
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (!w_overflow)
                    else $error("rename_free_list: release into a full free list");
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rename_free_list.md
Name: rename_free_list

Overview:
- Parametrised physical-register free list for the rename stage of the superscalar core.
- Circular FIFO of free PRF ids with:
  - ALLOC_WIDTH-wide allocation for renamed destinations.
  - RELEASE_WIDTH-wide release of T_old at ROB retire.
  - Committed-head checkpoint, so a pipeline flush (ROB rollback) restores every speculatively allocated id in one cycle.
- Sits between decode/rename (alloc side) and ROB commit (release side).

Parameters:
- PRF_NUM, 64, number of physical registers.
- ARF_NUM, 32, number of architectural registers. PRF ids 0..ARF_NUM-1 are mapped at reset and are never initially free.
- PRF_WIDTH, 6, PRF id width; must equal $clog2(PRF_NUM).
- ALLOC_WIDTH, 2, allocation lanes per cycle.
- RELEASE_WIDTH, 2, retire/release lanes per cycle.
- Derived FL_DEPTH = PRF_NUM-ARF_NUM; must be a power of two (elaboration-time check). CNT_W = $clog2(FL_DEPTH)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_req  in  ALLOC_WIDTH  per-lane request for a new PRF id.
- alloc_prf_id  out  ALLOC_WIDTH*PRF_WIDTH  per-lane id (lane i at [i*PRF_WIDTH +: PRF_WIDTH]).
- alloc_ready  out  1  free list can satisfy all asserted alloc_req lanes this cycle.
- retire_valid  in  RELEASE_WIDTH  ROB retires this lane.
- retire_wb  in  RELEASE_WIDTH  retiring instruction wrote a register.
- retire_T_old  in  RELEASE_WIDTH*PRF_WIDTH  old PRF id to release.
- flush  in  1  rollback: discard all speculative allocations.
- free_count  out  CNT_W  registered number of free entries.
- err_overflow  out  1  sticky: a release was attempted while the list was full.

Behaviour:
- Storage:
  - FL_DEPTH entries of PRF_WIDTH.
  - Pointers head (spec alloc), commit_head, tail, each $clog2(FL_DEPTH)+1 bits including a wrap bit.
  - free_count = tail - head, modulo 2^(CNT_W).
- Reset (sync, highest priority, overrides every other input; legal mid-operation):
  - entry[i] = ARF_NUM+i.
  - head = commit_head = 0; tail = FL_DEPTH, i.e. wrap bit set, index 0.
  - free_count = FL_DEPTH, err_overflow = 0, alloc_ready = 1.
- Allocation:
  - Let n = popcount(alloc_req).
  - alloc_ready = (free_count >= n), combinational from registered state only. Same-cycle releases are not bypassed.
  - Lane i receives entry[head + popcount(alloc_req[i-1:0])]. Outputs are combinational from current head.
  - Unrequested lanes output don't-care and are checked only when requested.
  - Fire = alloc_ready & |alloc_req & !flush. All-or-nothing.
  - On fire, head += n at the clock edge. The new head is visible next cycle.
- Release:
  - For each lane with retire_valid & retire_wb, in lane order:
    - Write retire_T_old to entry[tail]; tail += 1.
    - commit_head += 1, since the retiring T was allocated from this list.
  - Lanes with retire_valid=1, retire_wb=0 do nothing.
  - A released id is allocatable from the next cycle.
- Flush:
  - head <= commit_head_next (commit_head including same-cycle retires).
  - Allocation is suppressed in the flush cycle.
  - Releases in the flush cycle are still applied.
- Simultaneous alloc and release (no flush): head and tail both update; free_count_next = free_count - n + releases.
- Full boundary: a release when free_count+releases would exceed FL_DEPTH sets err_overflow, which stays set until reset. The write is still performed (contents undefined after). Simulation assertion fires.
- Empty boundary: free_count=0 gives alloc_ready=0 whenever any lane is requested. alloc_ready=1 when alloc_req=0.
- Pointer wrap: indices wrap modulo FL_DEPTH; the wrap bit distinguishes full from empty.

Test Plan:
1. Reset, then alloc_req=2'b11 for two cycles -> ids 32,33 then 34,35; free_count 32->30->28.
2. Allocate 2/cycle for 16 cycles -> free_count=0. alloc_req=2'b01 -> alloc_ready=0, head/free_count unchanged. alloc_req=0 -> alloc_ready=1.
3. From empty, retire lanes {valid,wb}={1,1},{1,1}, T_old=5,9 -> next cycle free_count=2; alloc 2'b11 returns 5,9 after the wrap.
4. Flush recovery:
   - From reset, alloc 3 cycles x2 -> head=6, free_count=26.
   - Retire two wb lanes T_old=3,4 -> commit_head=2, tail=34, free_count=28.
   - Pulse flush -> head=2, free_count=32; next alloc 2'b11 returns 34,35.
5. Same cycle flush + alloc 2'b11 + one wb retire (T_old=7) -> no allocation; commit_head+1; head=new commit_head; 7 written at tail.
6. Sparse lanes: alloc_req=2'b10 at head id 32 -> lane1=32, head+1. Retire with wb=0 -> no count change. Release at free_count=32 -> err_overflow=1, stays 1 until reset.
